// File: rtl/gpio_local_ram.sv
// CPU-bus slave: byte-writable local RAM plus a small GPIO register bank behind one decoder.
// RAM reads answer two cycles after the command; GPIO and unmapped reads answer after one.
module gpio_local_ram #(
    parameter int LOCAL_RAM_SIZE_KB = 8,
    parameter int NR_GPIOS          = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_cmd_valid,
    output logic                mem_cmd_ready,
    input  logic                mem_cmd_wr,
    input  logic [31:0]         mem_cmd_addr,
    input  logic [31:0]         mem_cmd_wdata,
    input  logic [3:0]          mem_cmd_be,
    output logic                mem_rsp_ready,
    output logic [31:0]         mem_rsp_rdata,
    output logic [NR_GPIOS-1:0] gpio_oe,
    output logic [NR_GPIOS-1:0] gpio_do,
    input  logic [NR_GPIOS-1:0] gpio_di
);

    localparam int          RAM_WORDS = LOCAL_RAM_SIZE_KB * 256;
    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(LOCAL_RAM_SIZE_KB * 1024);

    function automatic logic [31:0] zext_gpio(input logic [NR_GPIOS-1:0] v);
        zext_gpio = '0;
        zext_gpio[NR_GPIOS-1:0] = v;
    endfunction

    logic [31:0] ram_q [RAM_WORDS];

    logic              ram_hit, gpio_hit, rd_cmd, wr_cmd;
    logic [RAM_AW-1:0] ram_idx;
    logic [11:0]       gpio_off;

    logic                sel_ram_d, sel_ram_q, sel_gpio_d, sel_gpio_q;
    logic                vld_ram_p1_d, vld_ram_p1_q, vld_ram_p2_d, vld_ram_p2_q;
    logic                vld_io_p1_d, vld_io_p1_q;
    logic [NR_GPIOS-1:0] oe_d, oe_q, do_d, do_q;
    logic [NR_GPIOS-1:0] di_meta_d, di_meta_q, di_sync_d, di_sync_q;
    logic [31:0]         gpio_rdata_d, gpio_rdata_q;
    logic [31:0]         ram_rdata_p1_q, ram_rdata_p2_d, ram_rdata_p2_q;

    assign mem_cmd_ready = 1'b1;
    assign gpio_oe       = oe_q;
    assign gpio_do       = do_q;

    always_comb begin
        ram_hit  = (mem_cmd_addr < RAM_BYTES);
        gpio_hit = (mem_cmd_addr[31:16] == 16'hF000);
        ram_idx  = mem_cmd_addr[RAM_AW+1:2];
        gpio_off = mem_cmd_addr[11:0];
        rd_cmd   = mem_cmd_valid & ~mem_cmd_wr;
        wr_cmd   = mem_cmd_valid & mem_cmd_wr;

        sel_ram_d  = mem_cmd_valid ? ram_hit  : sel_ram_q;
        sel_gpio_d = mem_cmd_valid ? gpio_hit : sel_gpio_q;

        vld_ram_p1_d   = rd_cmd & ram_hit;
        vld_ram_p2_d   = vld_ram_p1_q;
        vld_io_p1_d    = rd_cmd & ~ram_hit;
        ram_rdata_p2_d = ram_rdata_p1_q;

        di_meta_d = gpio_di;
        di_sync_d = di_meta_q;

        // GPIO writes are full-word; byte enables only matter for the RAM.
        oe_d = oe_q;
        do_d = do_q;
        if (wr_cmd && gpio_hit) begin
            if (gpio_off == 12'h000) oe_d = mem_cmd_wdata[NR_GPIOS-1:0];
            if (gpio_off == 12'h004) do_d = mem_cmd_wdata[NR_GPIOS-1:0];
        end

        gpio_rdata_d = gpio_rdata_q;
        if (rd_cmd && gpio_hit) begin
            case (gpio_off)
                12'h000: gpio_rdata_d = zext_gpio(oe_q);
                12'h004: gpio_rdata_d = zext_gpio(do_q);
                12'h008: gpio_rdata_d = zext_gpio(di_sync_q);
                default: gpio_rdata_d = '0;
            endcase
        end
    end

    // Stage p1: command captured; control flops are the only ones reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_ram_q    <= 1'b0;
            sel_gpio_q   <= 1'b0;
            vld_ram_p1_q <= 1'b0;
            vld_ram_p2_q <= 1'b0;
            vld_io_p1_q  <= 1'b0;
            oe_q         <= '0;
            do_q         <= '0;
            di_meta_q    <= '0;
            di_sync_q    <= '0;
        end else begin
            sel_ram_q    <= sel_ram_d;
            sel_gpio_q   <= sel_gpio_d;
            vld_ram_p1_q <= vld_ram_p1_d;
            vld_ram_p2_q <= vld_ram_p2_d;
            vld_io_p1_q  <= vld_io_p1_d;
            oe_q         <= oe_d;
            do_q         <= do_d;
            di_meta_q    <= di_meta_d;
            di_sync_q    <= di_sync_d;
        end
    end

    always_ff @(posedge clk) begin
        gpio_rdata_q <= gpio_rdata_d;
        if (wr_cmd && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_cmd_be[b]) ram_q[ram_idx][8*b +: 8] <= mem_cmd_wdata[8*b +: 8];
            end
        end
        if (vld_ram_p1_d) ram_rdata_p1_q <= ram_q[ram_idx];
    end

    // Stage p2: RAM read data re-registered before it reaches the bus.
    always_ff @(posedge clk) begin
        ram_rdata_p2_q <= ram_rdata_p2_d;
    end

    always_comb begin
        mem_rsp_rdata = '0;
        mem_rsp_ready = vld_io_p1_q;
        if (sel_ram_q) begin
            mem_rsp_rdata = ram_rdata_p2_q;
            mem_rsp_ready = vld_ram_p2_q;
        end else if (sel_gpio_q) begin
            mem_rsp_rdata = gpio_rdata_q;
        end
        // A response already in the pipe must not show while reset is held.
        if (reset) mem_rsp_ready = 1'b0;
    end

endmodule

// File: tb/tb_gpio_local_ram.sv
// Self-checking bench for gpio_local_ram: directed scenarios plus a randomized mix
// checked against a word-array / register reference model.
module tb_gpio_local_ram;

    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
    logic [31:0]   mem_cmd_addr, mem_cmd_wdata;
    logic [3:0]    mem_cmd_be;
    logic          mem_rsp_ready;
    logic [31:0]   mem_rsp_rdata;
    logic [NR-1:0] gpio_oe, gpio_do, gpio_di;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    logic [31:0]   ram_m [16];
    logic [31:0]   pool  [16];
    logic [NR-1:0] oe_m, do_m, di_m;

    gpio_local_ram #(.LOCAL_RAM_SIZE_KB(8), .NR_GPIOS(NR)) dut (
        .clk(clk), .reset(reset),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_be(mem_cmd_be),
        .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
        .gpio_oe(gpio_oe), .gpio_do(gpio_do), .gpio_di(gpio_di)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Write command for one cycle; returns how many response pulses followed (should be 0).
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             output int pulses);
        @(negedge clk);
        mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b1;
        mem_cmd_addr = a; mem_cmd_wdata = d; mem_cmd_be = be;
        @(negedge clk);
        mem_cmd_valid = 1'b0; mem_cmd_wr = 1'b0;
        pulses = 0;
        if (mem_rsp_ready) pulses++;
    endtask

    // Read command; lat = cycle of first response pulse (0 if none), extra pulses reported as 99.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(negedge clk);
        mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b0; mem_cmd_addr = a;
        mem_cmd_wdata = $urandom; mem_cmd_be = 4'($urandom);
        @(negedge clk);
        mem_cmd_valid = 1'b0;
        lat = 0; d = 'x;
        for (int i = 1; i <= 5; i++) begin
            if (mem_rsp_ready) begin
                if (lat == 0) begin lat = i; d = mem_rsp_rdata; end
                else lat = 99;
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (mem_rsp_ready !== 1'b0 || gpio_oe !== '0 || gpio_do !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b oe=%h do=%h, required 0/00/00",
                     mem_rsp_ready, gpio_oe, gpio_do);
        end
        reset = 1'b0;
        oe_m = '0; do_m = '0;
    endtask

    task automatic test_ram_basic;
        logic [31:0] d; int lat, p;
        bus_write(32'h10, 32'hDEADBEEF, 4'hF, p);
        bus_read(32'h10, d, lat);
        vectors++;
        if (lat !== 2 || d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ram_basic: lat=%0d data=%h, required lat=2 data=deadbeef", lat, d);
        end
    endtask

    task automatic test_byte_enable;
        logic [31:0] d; int lat, p;
        bus_write(32'h20, 32'h11223344, 4'hF, p);
        bus_write(32'h20, 32'hAABBCCDD, 4'b0101, p);
        bus_read(32'h20, d, lat);
        vectors++;
        if (lat !== 2 || d !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_enable: lat=%0d data=%h, required lat=2 data=11bb33dd", lat, d);
        end
    endtask

    task automatic test_gpio;
        logic [31:0] d; int lat, p;
        bus_write(32'hF0000004, 32'hA5, 4'h0, p);
        vectors++;
        if (gpio_do !== 8'hA5) begin
            errors++; $display("FAIL gpio_do_write: do=%h, required a5", gpio_do);
        end
        bus_write(32'hF0000000, 32'h0F, 4'h1, p);
        vectors++;
        if (gpio_oe !== 8'h0F) begin
            errors++; $display("FAIL gpio_oe_write: oe=%h, required 0f", gpio_oe);
        end
        bus_read(32'hF0000004, d, lat);
        vectors++;
        if (lat !== 1 || d !== 32'hA5) begin
            errors++;
            $display("FAIL gpio_do_read: lat=%0d data=%h, required lat=1 data=000000a5", lat, d);
        end
        bus_write(32'hF0000004, 32'hFFFFFFFF, 4'hF, p);
        bus_read(32'hF0000004, d, lat);
        vectors++;
        if (lat !== 1 || d !== 32'h000000FF) begin
            errors++;
            $display("FAIL gpio_upper_bits: lat=%0d data=%h, required lat=1 data=000000ff", lat, d);
        end
        bus_read(32'hF000000C, d, lat);
        vectors++;
        if (lat !== 1 || d !== 32'h0) begin
            errors++;
            $display("FAIL gpio_unused_off: lat=%0d data=%h, required lat=1 data=0", lat, d);
        end
        oe_m = 8'h0F; do_m = 8'hFF;
    endtask

    task automatic test_di_sync;
        logic [31:0] d; int lat;
        gpio_di = 8'h3C;
        repeat (3) @(negedge clk);
        bus_read(32'hF0000008, d, lat);
        vectors++;
        if (lat !== 1 || d !== 32'h3C) begin
            errors++;
            $display("FAIL di_settled: lat=%0d data=%h, required lat=1 data=0000003c", lat, d);
        end
        // pin changes one cycle before the read command: the old level is still reported
        gpio_di = 8'hC3;
        bus_read(32'hF0000008, d, lat);
        vectors++;
        if (lat !== 1 || d !== 32'h3C) begin
            errors++;
            $display("FAIL di_too_new: lat=%0d data=%h, required lat=1 data=0000003c", lat, d);
        end
        bus_read(32'hF0000008, d, lat);
        vectors++;
        if (lat !== 1 || d !== 32'hC3) begin
            errors++;
            $display("FAIL di_later: lat=%0d data=%h, required lat=1 data=000000c3", lat, d);
        end
        di_m = 8'hC3;
    endtask

    task automatic test_void;
        logic [31:0] d; int lat, p;
        bus_write(32'h0, 32'h01234567, 4'hF, p);
        bus_read(32'h80000000, d, lat);
        vectors++;
        if (lat !== 1 || d !== 32'h0) begin
            errors++;
            $display("FAIL void_read: lat=%0d data=%h, required lat=1 data=0", lat, d);
        end
        bus_write(32'h80000000, 32'hFFFFFFFF, 4'hF, p);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_rsp_ready) p++;
        end
        vectors++;
        if (p !== 0) begin
            errors++; $display("FAIL void_write_rsp: pulses=%0d, required 0", p);
        end
        bus_write(32'h2000, 32'hCAFEF00D, 4'hF, p);
        bus_read(32'h2000, d, lat);
        vectors++;
        if (lat !== 1 || d !== 32'h0) begin
            errors++;
            $display("FAIL ram_past_end: lat=%0d data=%h, required lat=1 data=0", lat, d);
        end
        bus_read(32'h0, d, lat);
        vectors++;
        if (lat !== 2 || d !== 32'h01234567) begin
            errors++;
            $display("FAIL ram_unchanged: lat=%0d data=%h, required lat=2 data=01234567", lat, d);
        end
        vectors++;
        if (gpio_oe !== oe_m || gpio_do !== do_m) begin
            errors++;
            $display("FAIL gpio_unchanged: oe=%h do=%h, required oe=%h do=%h",
                     gpio_oe, gpio_do, oe_m, do_m);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        int lat;
        @(negedge clk);
        mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b1; mem_cmd_addr = 32'h1FFC;
        mem_cmd_wdata = 32'h5A5A1234; mem_cmd_be = 4'hF;
        @(negedge clk);
        mem_cmd_wr = 1'b0;
        @(negedge clk);
        mem_cmd_valid = 1'b0;
        lat = 0; d = 'x;
        for (int i = 1; i <= 4; i++) begin
            if (mem_rsp_ready && lat == 0) begin lat = i; d = mem_rsp_rdata; end
            if (i < 4) @(negedge clk);
        end
        vectors++;
        if (lat !== 2 || d !== 32'h5A5A1234) begin
            errors++;
            $display("FAIL raw_back_to_back: lat=%0d data=%h, required lat=2 data=5a5a1234", lat, d);
        end
    endtask

    task automatic test_random;
        logic [31:0] d, a, w, exp; int lat, p, k, kind;
        logic [3:0] be;
        for (int i = 0; i < 16; i++) begin
            pool[i] = ((i == 15) ? 32'd2047 : 32'((i * 131) % 2048)) << 2;
            ram_m[i] = $urandom;
            bus_write(pool[i], ram_m[i], 4'hF, p);
        end
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 5);
            k = $urandom_range(0, 15);
            w = $urandom;
            case (kind)
                0: begin
                    be = 4'($urandom);
                    bus_write(pool[k], w, be, p);
                    ram_m[k] = merge(ram_m[k], w, be);
                end
                1, 2: begin
                    bus_read(pool[k], d, lat);
                    vectors++;
                    if (lat !== 2 || d !== ram_m[k]) begin
                        errors++;
                        $display("FAIL rnd_ram_read @%h: lat=%0d data=%h, required lat=2 data=%h",
                                 pool[k], lat, d, ram_m[k]);
                    end
                end
                3: begin
                    a = (k[0]) ? 32'hF0000004 : 32'hF0000000;
                    bus_write(a, w, 4'($urandom), p);
                    if (k[0]) do_m = w[NR-1:0]; else oe_m = w[NR-1:0];
                    vectors++;
                    if (gpio_oe !== oe_m || gpio_do !== do_m || p !== 0) begin
                        errors++;
                        $display("FAIL rnd_gpio_pins: oe=%h do=%h pulses=%0d, required oe=%h do=%h pulses=0",
                                 gpio_oe, gpio_do, p, oe_m, do_m);
                    end
                end
                4: begin
                    a = 32'hF0000000 | (32'(k % 4) << 2);
                    case (k % 4)
                        0: exp = {24'h0, oe_m};
                        1: exp = {24'h0, do_m};
                        2: exp = {24'h0, di_m};
                        default: exp = 32'h0;
                    endcase
                    bus_read(a, d, lat);
                    vectors++;
                    if (lat !== 1 || d !== exp) begin
                        errors++;
                        $display("FAIL rnd_gpio_read @%h: lat=%0d data=%h, required lat=1 data=%h",
                                 a, lat, d, exp);
                    end
                end
                default: begin
                    a = 32'h2000 + (w & 32'h0FFF_FFFC);
                    if (a[31:16] == 16'hF000) a = 32'h80000000;
                    bus_read(a, d, lat);
                    vectors++;
                    if (lat !== 1 || d !== 32'h0) begin
                        errors++;
                        $display("FAIL rnd_void_read @%h: lat=%0d data=%h, required lat=1 data=0",
                                 a, lat, d);
                    end
                end
            endcase
        end
    endtask

    task automatic test_reset_inflight;
        int p, pulses;
        bus_write(32'hF0000000, 32'hFF, 4'hF, p);
        bus_write(32'hF0000004, 32'h55, 4'hF, p);
        @(negedge clk);
        mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b0; mem_cmd_addr = 32'h10;
        @(negedge clk);
        mem_cmd_valid = 1'b0;
        reset = 1'b1;
        pulses = 0;
        if (mem_rsp_ready) pulses++;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (gpio_oe !== '0 || gpio_do !== '0) begin
            errors++;
            $display("FAIL reset_gpio: oe=%h do=%h, required 00/00", gpio_oe, gpio_do);
        end
        for (int i = 0; i < 4; i++) begin
            if (mem_rsp_ready) pulses++;
            @(negedge clk);
        end
        vectors++;
        if (pulses !== 0) begin
            errors++; $display("FAIL reset_inflight_rsp: pulses=%0d, required 0", pulses);
        end
    endtask

    initial begin
        reset = 1'b1; mem_cmd_valid = 1'b0; mem_cmd_wr = 1'b0;
        mem_cmd_addr = '0; mem_cmd_wdata = '0; mem_cmd_be = '0; gpio_di = '0;
        oe_m = '0; do_m = '0; di_m = '0;
        test_reset;
        vectors++;
        if (mem_cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready: got %b, required 1", mem_cmd_ready);
        end
        test_ram_basic;
        test_byte_enable;
        test_gpio;
        test_di_sync;
        test_void;
        test_back_to_back;
        test_random;
        test_reset_inflight;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gpio_local_ram.md
Name: gpio_local_ram

Overview:
- CPU-bus slave combining a byte-writable local RAM and a GPIO register bank behind one address decoder.
- Sits directly on the single-master CPU memory bus of the bring-up SoC.
- Returns read data on a separate response strobe.
- Unmapped addresses complete harmlessly: reads return zero, writes are dropped.

Parameters:
- LOCAL_RAM_SIZE_KB, 8, RAM size in KiB. RAM depth is LOCAL_RAM_SIZE_KB*256 32-bit words.
- NR_GPIOS, 8, number of GPIO pins (1..32).

Ports:
- clk  in  1  single clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- mem_cmd_valid  in  1  command strobe
- mem_cmd_ready  out  1  command accept; constant 1
- mem_cmd_wr  in  1  1=write, 0=read
- mem_cmd_addr  in  32  byte address
- mem_cmd_wdata  in  32  write data
- mem_cmd_be  in  4  byte enables for writes; bit n covers wdata[8n+7:8n]
- mem_rsp_ready  out  1  one-cycle read-data-valid pulse
- mem_rsp_rdata  out  32  read data, valid when mem_rsp_ready=1
- gpio_oe  out  NR_GPIOS  pad output enables
- gpio_do  out  NR_GPIOS  pad output values
- gpio_di  in  NR_GPIOS  pad input values (asynchronous)

Behaviour:
- Address decode:
  - RAM: addr < LOCAL_RAM_SIZE_KB*1024.
  - GPIO: addr[31:16]==16'hF000.
  - Void: anything else.
  - Decode is combinational on mem_cmd_addr.
- Registered select:
  - One-hot select flops are loaded whenever mem_cmd_valid=1 and held otherwise.
  - Reset clears all select flops.
  - rdata/ready mux uses these flops; it outputs 0 / void-ready when no select is set.
- Bus rules:
  - Every command is accepted in the cycle it is valid.
  - Writes produce no response.
  - The master keeps at most one read outstanding and issues no command until its mem_rsp_ready pulse.
- RAM:
  - Word index = addr[log2(words)+1:2].
  - Write in the cmd cycle; each byte lane is written only when its be bit is set.
  - Read: array output registered in the cmd+1 edge, then re-registered. mem_rsp_ready is high exactly in cycle N+2 for a read command in cycle N.
  - Ready pipeline flops are cleared by reset. The data flops and array contents are not reset.
  - Read-after-write to the same word in the next command returns the new data.
- GPIO registers (addr[11:0]; other offsets read 0 and ignore writes):
  - 0x000 OE (RW, reset 0) drives gpio_oe.
  - 0x004 DO (RW, reset 0) drives gpio_do.
  - 0x008 DI (RO) returns synchronized gpio_di.
  - Register bits above NR_GPIOS read 0.
  - GPIO writes ignore mem_cmd_be (full-word write).
  - Write takes effect in the cmd cycle edge; the output changes in cycle N+1.
  - GPIO read: mem_rsp_ready high in cycle N+1, with rdata registered from the register value at cycle N.
- gpio_di synchronizer:
  - Two-flop synchronizer, reset to 0.
  - DI reads reflect the pin level 2 edges old.
- Void:
  - Read: mem_rsp_ready high in N+1 with rdata=0.
  - Write: no effect.
- Reset behaviour:
  - During reset: mem_rsp_ready=0, gpio_oe=0, gpio_do=0.
  - A read in flight when reset asserts produces no response.
- mem_rsp_rdata is don't-care when mem_rsp_ready=0.

Test Plan:
- Write 0xDEADBEEF to RAM 0x0010 with be=4'hF, then read 0x0010 → mem_rsp_ready pulses exactly 2 cycles after the read cmd with rdata=0xDEADBEEF.
- Write 0x11223344 to 0x0020 with be=4'hF, then 0xAABBCCDD with be=4'b0101; read → 0x11BB33DD.
- Write 0xA5 to 0xF0000004 and 0x0F to 0xF0000000 → gpio_do=8'hA5 and gpio_oe=8'h0F the cycle after each write; readback of 0xF0000004 gives 0x000000A5 one cycle after the cmd.
- Drive gpio_di=8'h3C and wait 3 cycles, then read 0xF0000008 → rdata=0x0000003C. Also show that a pin change 1 cycle before the read is not yet visible.
- Read 0x80000000 (void) → ready one cycle later with rdata=0. Write 0x80000000 → no ready pulse and RAM/GPIO unchanged. Read of RAM address 0x2000 (first byte past 8 KiB) → void behaviour.
- With OE=0xFF and a read outstanding, assert reset for one cycle → gpio_oe/gpio_do=0 and no mem_rsp_ready pulse follows.
